// File: rtl/count_run_ctrl_if.sv
// Counter-side bundle of the run-control sequencer: enable/clear
// towards the counter, count feedback and run status.
interface count_run_ctrl_if;
    logic [7:0] cnt_val;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       running;

    modport master (
        input  cnt_val,
        output cnt_en,
        output cnt_clr,
        output state,
        output running
    );

    modport slave (
        output cnt_val,
        input  cnt_en,
        input  cnt_clr,
        input  state,
        input  running
    );
endinterface

// File: rtl/count_run_ctrl.sv
// Run-control sequencer: button sync/debounce, prescaled count
// enable, IDLE/RUN/PAUSE/DONE sequencing with optional auto-stop.
module count_run_ctrl #(
    parameter int DIV_W    = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_ss,
    input  logic             btn_clr,
    input  logic [DIV_W-1:0] div_val,
    input  logic             auto_stop,
    input  logic [7:0]       stop_val,
    count_run_ctrl_if.master bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam int DBW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

    logic [1:0]          btn;
    logic [1:0]          s1;
    logic [1:0]          s2;
    logic [1:0]          db;
    logic [1:0]          db_d;
    logic [1:0]          evt;
    logic [1:0][DBW-1:0] dbc;

    logic             ss_evt;
    logic             clr_evt;
    logic             stop_hit;
    logic             tick;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             running;
    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] pre_nx;

    assign btn = {btn_clr, btn_ss};

    // bit 0 = start/stop, bit 1 = clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            dbc  <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    dbc[i] <= '0;
                end else if (dbc[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    dbc[i] <= '0;
                end else begin
                    dbc[i] <= dbc[i] + DBW'(1);
                end
            end
        end
    end

    assign evt      = db & ~db_d;
    assign ss_evt   = evt[0];
    assign clr_evt  = evt[1];
    assign stop_hit = auto_stop & (bus.cnt_val == stop_val);
    assign tick     = (pre >= div_val);

    always_comb begin
        state_nx = state;
        if (clr_evt) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (ss_evt) state_nx = RUN;
                RUN: begin
                    if (stop_hit)    state_nx = DONE;
                    else if (ss_evt) state_nx = PAUSE;
                end
                PAUSE: if (ss_evt) state_nx = RUN;
                DONE:  state_nx = DONE;
            endcase
        end
    end

    // the RUN cycle that carries the pause event still counts
    always_comb begin
        pre_nx = pre;
        if (state_nx == IDLE || state_nx == DONE) begin
            pre_nx = '0;
        end else if (state == RUN) begin
            pre_nx = tick ? '0 : pre + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            running <= 1'b0;
            pre     <= '0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
            pre     <= pre_nx;
        end
    end

    assign bus.cnt_en  = rst_n & (state == RUN) & tick
                       & ~clr_evt & ~ss_evt & ~stop_hit;
    assign bus.cnt_clr = rst_n & clr_evt;
    assign bus.state   = state;
    assign bus.running = running;
endmodule

// File: doc/count_run_ctrl.md
# count_run_ctrl

Run-control sequencer for the 8-bit display counter: debounces the start/stop and clear buttons, generates prescaled count-enable ticks, and clears the counter on command. It holds an IDLE/RUN/PAUSE/DONE state machine with an optional auto-stop at a programmed count value. It sits between the pad inputs and the counter/7-segment datapath, and replaces direct pin-level enable of the counter.

## Interface

- DIV_W, 16, prescaler width
- DEBOUNCE, 4, consecutive stable cycles required to accept a button level change; minimum 1
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk
- btn_clr  input  1  raw clear button, active-high, asynchronous to clk
- div_val  input  DIV_W  tick period minus 1; sampled live
- auto_stop  input  1  enables stop at stop_val
- stop_val  input  8  terminal count value
- cnt_val  input  8  current counter value, fed back from the counter
- cnt_en  output  1  count-enable; the counter increments on the edge where this is high
- cnt_clr  output  1  one-cycle clear pulse to the counter
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- running  output  1  high in RUN

## Operation

- Input conditioning, per button:
  - 2-flop synchronizer (s1, s2).
  - Debounce counter: reset to 0 whenever s2 equals the debounced level db.
  - While s2 differs from db, the counter increments. On the DEBOUNCE-th consecutive differing cycle, db <= s2 and the counter resets.
  - Event = db & ~db_d, where db_d is db delayed one cycle. Each event is exactly 1 cycle per press. Releases generate no event.
- stop_hit = auto_stop & (cnt_val == stop_val).
- State transitions, priority clr_evt > stop_hit > ss_evt:
  - Any state, clr_evt: go to IDLE; cnt_clr=1 for that cycle.
  - IDLE, ss_evt: go to RUN, with the prescaler at 0.
  - RUN, stop_hit: go to DONE.
  - RUN, ss_evt: go to PAUSE.
  - PAUSE, ss_evt: go to RUN; the prescaler resumes from its held value.
  - DONE: ss_evt is ignored; only clear exits.
- Prescaler (pre, DIV_W bits):
  - Held at 0 in IDLE and DONE.
  - Held at its current value in PAUSE.
  - In RUN: if pre >= div_val, pre <= 0 (a tick); otherwise pre <= pre+1.
  - The ">=" comparison keeps the prescaler safe when div_val is reduced mid-run.
- cnt_en = (state==RUN) & (pre >= div_val) & ~clr_evt & ~ss_evt & ~stop_hit. This is combinational from registered state and event flags, so the counter never overshoots stop_val.
- cnt_clr = clr_evt, combinational from the registered edge flag.
- div_val=0 gives cnt_en on every RUN cycle.
- Counter arithmetic is not owned here. Counter wrap 0xFF→0x00 continues unless auto_stop is set.

## Timing

- Reset (rst_n low at a rising edge): state=IDLE, running=0, pre=0, synchronizers/db/db_d/debounce counters=0. cnt_en=0 and cnt_clr=0 while in reset.
  - Reset mid-RUN aborts immediately.
  - A button still held across reset release produces one event after the full debounce latency.
- Press latency: the input is first sampled high at edge 1. s2 is high after edge 2, db after edge 2+DEBOUNCE, and the event is high during the following cycle. State changes at edge DEBOUNCE+3.
- Glitch filtering: a pulse or bounce shorter than DEBOUNCE cycles at s2 produces no event.
- Tick spacing in RUN: exactly div_val+1 cycles. The first tick after IDLE→RUN occurs div_val+1 cycles after entering RUN.
- Pause: cycles spent in PAUSE do not count toward the tick period.
- Auto-stop: the cycle after the tick that makes cnt_val==stop_val, cnt_en is suppressed, and the next edge enters DONE.
  - If cnt_val already equals stop_val on entry to RUN, DONE follows one cycle later with no tick.
- Simultaneous clear and start/stop events: clear wins; the start/stop event is discarded.
- running and state are registered and update on the same edge.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with buttons toggling → state=00, running=0, cnt_en=0, cnt_clr=0 throughout and after release.
- Debounce (DEBOUNCE=4): btn_ss pulses of 1–3 cycles → no state change. A held press → IDLE→RUN exactly at edge 7, with one event only.
- Prescale (div_val=9): RUN for 100 cycles → exactly 10 cnt_en pulses, each 1 cycle, spaced 10 apart.
- Pause/resume (div_val=9): pause when pre=6, hold 20 cycles, resume → the next tick arrives 4 cycles after re-entering RUN.
- Auto-stop (auto_stop=1, stop_val=5, div_val=0, model counter from 0) → cnt_val stops at exactly 5, state=11, and further btn_ss presses are ignored. A clr press → cnt_clr pulse, state=00.
- Collision: btn_ss and btn_clr pressed on the same cycle while in RUN → single cnt_clr pulse, state=IDLE, no cnt_en in that cycle, no PAUSE.
